// File: rtl/c2f_chunk_streamer_if.sv
// Port bundle for the CPU->FPGA chunk streamer: ring pointers, chunk RAM read port,
// 64-bit output stream, acknowledge/count outputs and FSM debug taps.
interface c2f_chunk_streamer_if #(
   parameter int PTR_NBITS    = 2,
   parameter int OFFSET_NBITS = 4
);
   logic [PTR_NBITS-1:0]    wrPtr_in;
   logic [PTR_NBITS-1:0]    rdPtr_in;
   logic                    dtAck_out;
   logic [OFFSET_NBITS-1:0] rdOffset_out;
   logic [63:0]             rdData_in;
   // Stream: a word moves on every cycle where valid_out && ready_in; once valid_out
   // is high it stays high and data_out stays fixed until that word is taken.
   logic [63:0]             data_out;
   logic                    valid_out;
   logic                    ready_in;
   logic [31:0]             chunkCount_out;
   logic [2:0]              dbgState_out;
   logic [1:0]              dbgFill_out;

   modport master (
      input  wrPtr_in, rdPtr_in, rdData_in, ready_in,
      output dtAck_out, rdOffset_out, data_out, valid_out, chunkCount_out,
      dbgState_out, dbgFill_out
   );

   modport slave (
      output wrPtr_in, rdPtr_in, rdData_in, ready_in,
      input  dtAck_out, rdOffset_out, data_out, valid_out, chunkCount_out,
      dbgState_out, dbgFill_out
   );
endinterface

// File: rtl/c2f_chunk_streamer.sv
// Drains filled ring chunks word-by-word from the synchronous chunk RAM into a
// 64-bit valid/ready stream through a 2-entry FIFO, acking each chunk once emptied.
module c2f_chunk_streamer #(
   parameter int          PTR_NBITS    = 2,
   parameter int          OFFSET_NBITS = 4,
   // reset value of the ack counter; nonzero only to exercise the wrap path early
   parameter logic [31:0] COUNT_INIT   = 32'd0
) (
   input logic                  clk_in,
   input logic                  reset_in,
   c2f_chunk_streamer_if.master bus
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DRAIN  = 3'd2,
      ACK    = 3'd3,
      SETTLE = 3'd4
   } state_t;

   localparam logic [OFFSET_NBITS-1:0] LAST_OFFSET = '1;
   localparam logic [OFFSET_NBITS-1:0] OFFSET_ONE  = OFFSET_NBITS'(1);

   state_t                  state;
   logic [OFFSET_NBITS-1:0] rdOffset;
   logic                    inFlight;
   logic [63:0]             fifoMem [2];
   logic                    wrIdx;
   logic                    rdIdx;
   logic [1:0]              fill;
   logic                    dtAck;
   logic [31:0]             chunkCount;

   logic                    chunkAvail;
   logic                    pop;
   logic                    issue;
   logic [2:0]              budget;

   // A read is only issued when its word is guaranteed a FIFO slot on capture.
   always_comb begin
      chunkAvail = (bus.wrPtr_in != bus.rdPtr_in);
      pop        = (fill != 2'd0) && bus.ready_in;
      budget     = {1'b0, fill} + {2'b00, inFlight} - {2'b00, pop};
      issue      = (state == FETCH) && (budget < 3'd2);
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state      <= IDLE;
         rdOffset   <= '0;
         inFlight   <= 1'b0;
         fifoMem[0] <= '0;
         fifoMem[1] <= '0;
         wrIdx      <= 1'b0;
         rdIdx      <= 1'b0;
         fill       <= 2'd0;
         dtAck      <= 1'b0;
         chunkCount <= COUNT_INIT;
      end else begin
         dtAck    <= 1'b0;
         inFlight <= issue;
         if (inFlight) begin
            fifoMem[wrIdx] <= bus.rdData_in;
            wrIdx          <= ~wrIdx;
         end
         if (pop) begin
            rdIdx <= ~rdIdx;
         end
         fill <= fill + {1'b0, inFlight} - {1'b0, pop};

         case (state)
            IDLE: begin
               rdOffset <= '0;
               if (chunkAvail) begin
                  state <= FETCH;
               end
            end
            FETCH: begin
               if (issue) begin
                  rdOffset <= rdOffset + OFFSET_ONE;
                  if (rdOffset == LAST_OFFSET) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if ((fill == 2'd0) && !inFlight) begin
                  state      <= ACK;
                  dtAck      <= 1'b1;
                  chunkCount <= chunkCount + 32'd1;
               end
            end
            ACK: begin
               state <= SETTLE;
            end
            SETTLE: begin
               // rdPtr_in advances during this cycle, so IDLE sees the new pointer
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      bus.dtAck_out      = dtAck;
      bus.rdOffset_out   = rdOffset;
      bus.data_out       = fifoMem[rdIdx];
      bus.valid_out      = (fill != 2'd0);
      bus.chunkCount_out = chunkCount;
      bus.dbgState_out   = state;
      bus.dbgFill_out    = fill;
   end
endmodule

// File: tb/tb_c2f_chunk_streamer.sv
// Directed bench for c2f_chunk_streamer: synchronous RAM model, transceiver pointer
// model, scenario tasks with inline checks and a single summary line.
module tb_c2f_chunk_streamer;
   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   logic [63:0] ram [64];
   logic [63:0] got_q [$];
   logic [63:0] exp_q [$];

   c2f_chunk_streamer_if #(.PTR_NBITS(2), .OFFSET_NBITS(4)) bus ();
   c2f_chunk_streamer_if #(.PTR_NBITS(2), .OFFSET_NBITS(4)) busW ();

   c2f_chunk_streamer #(.PTR_NBITS(2), .OFFSET_NBITS(4)) dut (
      .clk_in(clk), .reset_in(rst), .bus(bus.master)
   );

   c2f_chunk_streamer #(.PTR_NBITS(2), .OFFSET_NBITS(4), .COUNT_INIT(32'hFFFF_FFFF)) dutWrap (
      .clk_in(clk), .reset_in(rst), .bus(busW.master)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) bus.rdData_in  <= ram[{bus.rdPtr_in, bus.rdOffset_out}];
   always @(posedge clk) busW.rdData_in <= ram[{busW.rdPtr_in, busW.rdOffset_out}];

   task automatic apply_reset(input logic [1:0] rdP, input logic [1:0] wrP);
      rst = 1'b1;
      bus.rdPtr_in  = rdP;
      bus.wrPtr_in  = wrP;
      bus.ready_in  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // driver: steps ready_in per pattern, collects transferred words into got_q,
   // advances rdPtr_in on every ack like the transceiver
   task automatic drive_stream(input int wantWords, input int wantAcks, input int pattern,
                               input int maxCycles, output int acks, output int stallBreaks,
                               output int maxFill, output int firstX, output int lastX,
                               output int ackX, output bit timedOut);
      int          k;
      int          tail;
      logic        prevStall;
      logic [63:0] prevData;
      acks = 0; stallBreaks = 0; maxFill = 0; firstX = -1; lastX = -1; ackX = -1;
      timedOut = 1'b0; k = 0; tail = -1; prevStall = 1'b0; prevData = '0;
      while (1) begin
         @(negedge clk);
         case (pattern)
            1:       bus.ready_in = ((k % 4) == 0) || ((k % 4) == 3);
            default: bus.ready_in = 1'b1;
         endcase
         if (prevStall && (!bus.valid_out || (bus.data_out !== prevData))) stallBreaks++;
         prevStall = bus.valid_out && !bus.ready_in;
         prevData  = bus.data_out;
         if (bus.valid_out && bus.ready_in) begin
            got_q.push_back(bus.data_out);
            if (firstX < 0) firstX = k;
            lastX = k;
         end
         if (bus.dtAck_out) begin
            acks++;
            ackX = k;
            bus.rdPtr_in = bus.rdPtr_in + 2'd1;
         end
         if (int'(bus.dbgFill_out) > maxFill) maxFill = int'(bus.dbgFill_out);
         k++;
         if ((wantAcks == 0) && (got_q.size() == wantWords)) break;
         if ((wantAcks > 0) && (acks == wantAcks) && (tail < 0)) tail = 6;
         if (tail == 0) break;
         if (tail > 0) tail--;
         if (k >= maxCycles) begin
            timedOut = 1'b1;
            break;
         end
      end
   endtask

   task automatic build_expected(input int firstChunk, input int nChunks);
      exp_q.delete();
      for (int c = 0; c < nChunks; c++) begin
         for (int i = 0; i < 16; i++) begin
            exp_q.push_back(64'(256 * (((firstChunk + c) % 4) + 1) + i));
         end
      end
   endtask

   task automatic compare_words(input string tag);
      vectors++;
      if (got_q.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL %s word_count got %0d want %0d", tag, got_q.size(), exp_q.size());
      end
      for (int i = 0; (i < got_q.size()) && (i < exp_q.size()); i++) begin
         vectors++;
         if (got_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL %s word[%0d] got %h want %h", tag, i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.rdPtr_in = 2'd0; bus.wrPtr_in = 2'd1; bus.ready_in = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", bus.valid_out); end
      vectors++;
      if (bus.dtAck_out !== 1'b0) begin miscompares++; $display("FAIL reset_ack got %b want 0", bus.dtAck_out); end
      vectors++;
      if (bus.rdOffset_out !== 4'd0) begin miscompares++; $display("FAIL reset_offset got %0d want 0", bus.rdOffset_out); end
      vectors++;
      if (bus.data_out !== 64'd0) begin miscompares++; $display("FAIL reset_data got %h want 0", bus.data_out); end
      vectors++;
      if (bus.chunkCount_out !== 32'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", bus.chunkCount_out); end
      vectors++;
      if (bus.dbgState_out !== 3'd0) begin miscompares++; $display("FAIL reset_state got %0d want 0", bus.dbgState_out); end
      vectors++;
      if (busW.chunkCount_out !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL reset_count_preload got %h want ffffffff", busW.chunkCount_out); end
   endtask

   task automatic test_single_chunk();
      int acks, sb, mf, fx, lx, ax;
      bit to;
      apply_reset(2'd0, 2'd0);
      got_q.delete();
      build_expected(0, 1);
      bus.wrPtr_in = 2'd1;
      drive_stream(16, 1, 0, 300, acks, sb, mf, fx, lx, ax, to);
      vectors++;
      if (to) begin miscompares++; $display("FAIL single_timeout got timeout want done"); end
      compare_words("single");
      vectors++;
      if (acks !== 1) begin miscompares++; $display("FAIL single_acks got %0d want 1", acks); end
      vectors++;
      if ((lx - fx) !== 15) begin miscompares++; $display("FAIL single_consecutive got span %0d want 15", lx - fx); end
      vectors++;
      if (!(ax > lx)) begin miscompares++; $display("FAIL single_ack_after_last got ack %0d last %0d want ack later", ax, lx); end
      vectors++;
      if (bus.chunkCount_out !== 32'd1) begin miscompares++; $display("FAIL single_count got %0d want 1", bus.chunkCount_out); end
      vectors++;
      if (bus.dbgState_out !== 3'd0) begin miscompares++; $display("FAIL single_idle got state %0d want 0", bus.dbgState_out); end
   endtask

   task automatic test_backpressure();
      int acks, sb, mf, fx, lx, ax;
      bit to;
      apply_reset(2'd0, 2'd0);
      got_q.delete();
      build_expected(0, 1);
      bus.wrPtr_in = 2'd1;
      drive_stream(16, 1, 1, 300, acks, sb, mf, fx, lx, ax, to);
      vectors++;
      if (to) begin miscompares++; $display("FAIL bp_timeout got timeout want done"); end
      compare_words("bp");
      vectors++;
      if (sb !== 0) begin miscompares++; $display("FAIL bp_stall_stable got %0d breaks want 0", sb); end
      vectors++;
      if (mf > 2) begin miscompares++; $display("FAIL bp_fifo_fill got %0d want <=2", mf); end
      vectors++;
      if (acks !== 1) begin miscompares++; $display("FAIL bp_acks got %0d want 1", acks); end
   endtask

   task automatic test_ring_wrap();
      int acks, sb, mf, fx, lx, ax;
      bit to;
      apply_reset(2'd1, 2'd1);
      got_q.delete();
      build_expected(1, 3);
      bus.wrPtr_in = 2'd0;
      drive_stream(48, 3, 0, 600, acks, sb, mf, fx, lx, ax, to);
      vectors++;
      if (to) begin miscompares++; $display("FAIL ring_timeout got timeout want done"); end
      compare_words("ring");
      vectors++;
      if (acks !== 3) begin miscompares++; $display("FAIL ring_acks got %0d want 3", acks); end
      vectors++;
      if (bus.rdPtr_in !== 2'd0) begin miscompares++; $display("FAIL ring_rdptr got %0d want 0", bus.rdPtr_in); end
      vectors++;
      if (bus.dbgState_out !== 3'd0) begin miscompares++; $display("FAIL ring_idle got state %0d want 0", bus.dbgState_out); end
      vectors++;
      if (bus.chunkCount_out !== 32'd3) begin miscompares++; $display("FAIL ring_count got %0d want 3", bus.chunkCount_out); end
   endtask

   task automatic test_empty_ring();
      int badValid, badAck, badOffset;
      badValid = 0; badAck = 0; badOffset = 0;
      bus.wrPtr_in = bus.rdPtr_in;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         bus.ready_in = (i % 2) == 0;
         if (bus.valid_out !== 1'b0) badValid++;
         if (bus.dtAck_out !== 1'b0) badAck++;
         if (bus.rdOffset_out !== 4'd0) badOffset++;
      end
      vectors++;
      if (badValid !== 0) begin miscompares++; $display("FAIL empty_valid got %0d cycles high want 0", badValid); end
      vectors++;
      if (badAck !== 0) begin miscompares++; $display("FAIL empty_ack got %0d cycles high want 0", badAck); end
      vectors++;
      if (badOffset !== 0) begin miscompares++; $display("FAIL empty_offset got %0d cycles nonzero want 0", badOffset); end
   endtask

   task automatic test_reset_mid_chunk();
      int acks, sb, mf, fx, lx, ax, holdAcks;
      bit to;
      apply_reset(2'd0, 2'd0);
      got_q.delete();
      bus.wrPtr_in = 2'd1;
      drive_stream(5, 0, 0, 100, acks, sb, mf, fx, lx, ax, to);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      vectors++;
      if (bus.valid_out !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got %b want 0", bus.valid_out); end
      vectors++;
      if (bus.rdOffset_out !== 4'd0) begin miscompares++; $display("FAIL midrst_offset got %0d want 0", bus.rdOffset_out); end
      vectors++;
      if (bus.data_out !== 64'd0) begin miscompares++; $display("FAIL midrst_data got %h want 0", bus.data_out); end
      vectors++;
      if (bus.dbgState_out !== 3'd0) begin miscompares++; $display("FAIL midrst_state got %0d want 0", bus.dbgState_out); end
      holdAcks = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.dtAck_out !== 1'b0) holdAcks++;
      end
      vectors++;
      if (holdAcks !== 0) begin miscompares++; $display("FAIL midrst_no_ack got %0d acks want 0", holdAcks); end
      rst = 1'b0;
      got_q.delete();
      build_expected(0, 1);
      drive_stream(16, 1, 0, 300, acks, sb, mf, fx, lx, ax, to);
      compare_words("midrst_restart");
      vectors++;
      if (acks !== 1) begin miscompares++; $display("FAIL midrst_acks got %0d want 1", acks); end
      vectors++;
      if (bus.chunkCount_out !== 32'd1) begin miscompares++; $display("FAIL midrst_count got %0d want 1", bus.chunkCount_out); end
   endtask

   task automatic test_counter_wrap();
      bit seen;
      seen = 1'b0;
      vectors++;
      if (busW.chunkCount_out !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL wrap_preload got %h want ffffffff", busW.chunkCount_out); end
      busW.wrPtr_in = 2'd1;
      for (int i = 0; (i < 80) && !seen; i++) begin
         @(negedge clk);
         if (busW.dtAck_out) seen = 1'b1;
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL wrap_ack_timeout got no ack want ack within 80 cycles");
      end else begin
         vectors++;
         if (busW.chunkCount_out !== 32'd0) begin miscompares++; $display("FAIL wrap_count got %h want 0", busW.chunkCount_out); end
      end
      busW.rdPtr_in = 2'd1;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 16; i++) begin
            ram[c * 16 + i] = 64'(256 * (c + 1) + i);
         end
      end
      busW.rdPtr_in = 2'd0;
      busW.wrPtr_in = 2'd0;
      busW.ready_in = 1'b1;
      test_reset();
      test_single_chunk();
      test_backpressure();
      test_ring_wrap();
      test_empty_ring();
      test_reset_mid_chunk();
      test_counter_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
